// File: rtl/simon_pkg.sv
// Shared types and helpers for the parametrised Simon controller.
package simon_pkg;

  typedef enum logic [3:0] {
    IDLE, GEN, SHOW_OFF, SHOW_ON, WAIT_REL, WAIT_PRESS, CHECK, ECHO, WIN, LOSE
  } state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One-hot of sym over up to 8 lanes; symbols at or beyond n give all zeros.
  function automatic logic [7:0] onehot(input logic [2:0] sym, input int n);
    onehot = '0;
    if (int'(sym) < n) onehot[sym] = 1'b1;
  endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Free-running 16-bit Galois LFSR used as the symbol source.
module simon_lfsr
  import simon_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= SEED;
    else     q <= q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
  end

endmodule

// File: rtl/simon_game_param.sv
// Simon controller with growing rounds, LFSR symbols and a press timeout.
// Outputs decode only from state and registers; btn never reaches an output combinationally.
module simon_game_param
  import simon_pkg::*;
#(
  parameter int          N_BTN       = 4,
  parameter int          MAX_LEN     = 16,
  parameter int          ON_CYC      = 200,
  parameter int          OFF_CYC     = 200,
  parameter int          TIMEOUT_CYC = 16000,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [N_BTN-1:0]             btn,
  output logic [N_BTN-1:0]             led,
  output logic                         busy,
  output logic [$clog2(MAX_LEN+1)-1:0] round,
  output logic                         win,
  output logic                         lose
);

  localparam int RW      = $clog2(MAX_LEN + 1);
  localparam int SYM_W   = $clog2(N_BTN);
  localparam int MAX_OO  = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int CNT_MAX = (MAX_OO > TIMEOUT_CYC) ? MAX_OO : TIMEOUT_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_t             state, state_nxt;
  logic [15:0]        lfsr_q;
  logic [SYM_W-1:0]   sym, cur_sym;
  logic [SYM_W-1:0]   mem [MAX_LEN];
  logic [RW-1:0]      round_nxt, idx, idx_nxt;
  logic [CW-1:0]      timer, timer_nxt;
  logic [N_BTN-1:0]   pbtn, pbtn_nxt, cur_oh;

  simon_lfsr #(.SEED(SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  assign sym = SYM_W'(lfsr_q % 16'(N_BTN));

  // Mux the symbol at idx without an index wider than the array.
  always_comb begin
    cur_sym = '0;
    for (int i = 0; i < MAX_LEN; i++)
      if (idx == RW'(i)) cur_sym = mem[i];
  end

  assign cur_oh = N_BTN'(onehot(3'(cur_sym), N_BTN));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      round <= '0;
      idx   <= '0;
      timer <= '0;
      pbtn  <= '0;
    end else begin
      state <= state_nxt;
      round <= round_nxt;
      idx   <= idx_nxt;
      timer <= timer_nxt;
      pbtn  <= pbtn_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == GEN)
      for (int i = 0; i < MAX_LEN; i++)
        if (round == RW'(i)) mem[i] <= sym;
  end

  always_comb begin
    state_nxt = state;
    round_nxt = round;
    idx_nxt   = idx;
    timer_nxt = timer;
    pbtn_nxt  = pbtn;
    unique case (state)
      IDLE: if (start) state_nxt = GEN;
      GEN: begin
        round_nxt = round + 1'b1;
        idx_nxt   = '0;
        timer_nxt = '0;
        state_nxt = SHOW_OFF;
      end
      SHOW_OFF: begin
        if (timer == CW'(OFF_CYC - 1)) begin
          timer_nxt = '0;
          if (idx < round) begin
            state_nxt = SHOW_ON;
          end else begin
            idx_nxt   = '0;
            state_nxt = WAIT_REL;
          end
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      SHOW_ON: begin
        if (timer == CW'(ON_CYC - 1)) begin
          timer_nxt = '0;
          idx_nxt   = idx + 1'b1;
          state_nxt = SHOW_OFF;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      WAIT_REL: begin
        if (btn == '0) begin
          timer_nxt = '0;
          state_nxt = WAIT_PRESS;
        end
      end
      // A press in the terminal cycle still wins over the timeout.
      WAIT_PRESS: begin
        if (btn != '0) begin
          pbtn_nxt  = btn;
          state_nxt = CHECK;
        end else if (timer == CW'(TIMEOUT_CYC - 1)) begin
          state_nxt = LOSE;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      CHECK: state_nxt = (pbtn == cur_oh) ? ECHO : LOSE;
      ECHO: begin
        if (btn == '0) begin
          if (idx + 1'b1 < round) begin
            idx_nxt   = idx + 1'b1;
            timer_nxt = '0;
            state_nxt = WAIT_PRESS;
          end else if (round == RW'(MAX_LEN)) begin
            state_nxt = WIN;
          end else begin
            state_nxt = GEN;
          end
        end
      end
      WIN, LOSE: begin
        if (start) begin
          round_nxt = '0;
          state_nxt = GEN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    led  = '0;
    busy = (state == SHOW_OFF) || (state == SHOW_ON);
    win  = (state == WIN);
    lose = (state == LOSE);
    case (state)
      SHOW_ON: led = cur_oh;
      ECHO:    led = pbtn;
      WIN:     led = '1;
      LOSE:    led = cur_oh;
      default: led = '0;
    endcase
  end

endmodule

// File: tb/tb_simon_game_param.sv
// Directed bench for simon_game_param: vector table for the first round, hand sequences for the rest.
module tb_simon_game_param;

  localparam int          N_BTN       = 4;
  localparam int          MAX_LEN     = 3;
  localparam int          ON_CYC      = 4;
  localparam int          OFF_CYC     = 2;
  localparam int          TIMEOUT_CYC = 20;
  localparam logic [15:0] SEED        = 16'hACE1;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic [3:0] btn   = 4'b0;
  logic [3:0] led;
  logic       busy, win, lose;
  logic [1:0] round;

  simon_game_param #(
    .N_BTN(N_BTN), .MAX_LEN(MAX_LEN), .ON_CYC(ON_CYC), .OFF_CYC(OFF_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC), .SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .btn(btn), .led(led),
    .busy(busy), .round(round), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  // Reference symbol source: Galois shift with taps 0xB400.
  logic [15:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= (m_lfsr >> 1) ^ ({16{m_lfsr[0]}} & 16'hB400);
  end

  int checks = 0;
  int errors = 0;
  int exp_mem [3];

  typedef struct {
    logic       rst;
    logic       start;
    int         btn_sym;   // >=0: press one-hot of exp_mem[btn_sym]; else btn_raw
    logic [3:0] btn_raw;
    int         led_sym;   // >=0: led shows exp_mem[led_sym]; else dark
    logic       busy;
    logic [1:0] round;
    logic       win;
    logic       lose;
    logic       gen;       // DUT is in GEN after this vector
  } vec_t;

  vec_t tbl[$];

  function automatic logic [3:0] oh(int k);
    oh = 4'b0001 << exp_mem[k];
  endfunction

  function automatic logic [3:0] rotl(logic [3:0] v);
    rotl = {v[2:0], v[3]};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_out(string name, logic [3:0] e_led, logic e_busy, logic [1:0] e_round,
                         logic e_win, logic e_lose);
    checks++;
    if ({led, busy, round, win, lose} !== {e_led, e_busy, e_round, e_win, e_lose}) begin
      errors++;
      $display("FAIL %s: got led=%b busy=%b round=%0d win=%b lose=%b, expected led=%b busy=%b round=%0d win=%b lose=%b",
               name, led, busy, round, win, lose, e_led, e_busy, e_round, e_win, e_lose);
    end
  endtask

  task automatic capture(int k);
    exp_mem[k] = int'(m_lfsr[1:0]);
  endtask

  task automatic add(logic r, logic s, int bs, logic [3:0] br, int ls, logic b,
                     logic [1:0] rd, logic g);
    vec_t v;
    v = '{r, s, bs, br, ls, b, rd, 1'b0, 1'b0, g};
    tbl.push_back(v);
  endtask

  // Entered at a negedge with the DUT in GEN; runs playback of k symbols into WAIT_REL.
  task automatic show(int k, logic [3:0] hb);
    logic [3:0] el;
    capture(k - 1);
    btn = hb;
    for (int c = 0; c < 2 + 6 * k; c++) begin
      el = 4'b0;
      if (c >= 2 && ((c - 2) % 6) < 4) el = oh((c - 2) / 6);
      step();
      chk_out($sformatf("show r%0d c%0d", k, c), el, 1'b1, 2'(k), 1'b0, 1'b0);
    end
    step();
    chk_out($sformatf("wait_rel r%0d", k), 4'b0, 1'b0, 2'(k), 1'b0, 1'b0);
  endtask

  task automatic to_press(int k);
    btn = 4'b0;
    step();
    chk_out($sformatf("wait_press r%0d", k), 4'b0, 1'b0, 2'(k), 1'b0, 1'b0);
  endtask

  // Correct press held for three sampled edges, then released; caller checks the follow-on state.
  task automatic press_ok(int j, int k);
    btn = oh(j);
    step();
    chk_out($sformatf("check r%0d i%0d", k, j), 4'b0, 1'b0, 2'(k), 1'b0, 1'b0);
    repeat (2) begin
      step();
      chk_out($sformatf("echo r%0d i%0d", k, j), oh(j), 1'b0, 2'(k), 1'b0, 1'b0);
    end
    btn = 4'b0;
    step();
  endtask

  task automatic new_game();
    start = 1'b1;
    step();
    start = 1'b0;
    chk_out("new game gen", 4'b0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] w;

    // rst/start/btn_sym/btn_raw/led_sym/busy/round/gen
    add(1, 1, -1, 4'hF, -1, 0, 0, 0);
    add(1, 0, -1, 4'h0, -1, 0, 0, 0);
    add(0, 0, -1, 4'h0, -1, 0, 0, 0);
    add(0, 1, -1, 4'h0, -1, 0, 0, 1);
    repeat (2) add(0, 0, -1, 4'h0, -1, 1, 1, 0);
    repeat (4) add(0, 0, -1, 4'hF,  0, 1, 1, 0);
    repeat (2) add(0, 0, -1, 4'h0, -1, 1, 1, 0);
    add(0, 0, -1, 4'h0, -1, 0, 1, 0);
    add(0, 0, -1, 4'h0, -1, 0, 1, 0);
    add(0, 0,  0, 4'h0, -1, 0, 1, 0);
    repeat (2) add(0, 0, 0, 4'h0, 0, 0, 1, 0);
    add(0, 0, -1, 4'h0, -1, 0, 1, 0);

    foreach (tbl[i]) begin
      rst   = tbl[i].rst;
      start = tbl[i].start;
      btn   = (tbl[i].btn_sym >= 0) ? oh(tbl[i].btn_sym) : tbl[i].btn_raw;
      step();
      if (tbl[i].gen) capture(int'(tbl[i].round));
      chk_out($sformatf("vec %0d", i),
              (tbl[i].led_sym >= 0) ? oh(tbl[i].led_sym) : 4'b0,
              tbl[i].busy, tbl[i].round, tbl[i].win, tbl[i].lose);
    end

    // Rounds 2 and 3 to a win; round 3 playback with a button held throughout.
    show(2, 4'b0);
    to_press(2);
    press_ok(0, 2);
    chk_out("r2 next press", 4'b0, 1'b0, 2'd2, 1'b0, 1'b0);
    press_ok(1, 2);
    chk_out("r2 done gen", 4'b0, 1'b0, 2'd2, 1'b0, 1'b0);
    show(3, 4'b0100);
    repeat (3) begin
      step();
      chk_out("held in wait_rel", 4'b0, 1'b0, 2'd3, 1'b0, 1'b0);
    end
    to_press(3);
    press_ok(0, 3);
    chk_out("r3 next press a", 4'b0, 1'b0, 2'd3, 1'b0, 1'b0);
    press_ok(1, 3);
    chk_out("r3 next press b", 4'b0, 1'b0, 2'd3, 1'b0, 1'b0);
    press_ok(2, 3);
    chk_out("win", 4'hF, 1'b0, 2'd3, 1'b1, 1'b0);
    step();
    chk_out("win hold", 4'hF, 1'b0, 2'd3, 1'b1, 1'b0);

    // Idle timeout: lose on WAIT_PRESS cycle 21.
    new_game();
    show(1, 4'b0);
    to_press(1);
    repeat (19) begin
      step();
      chk_out("timeout waiting", 4'b0, 1'b0, 2'd1, 1'b0, 1'b0);
    end
    step();
    chk_out("timeout lose", oh(0), 1'b0, 2'd1, 1'b0, 1'b1);

    // Press arriving on cycle 19 is accepted; then a wrong second press in round 2.
    new_game();
    show(1, 4'b0);
    to_press(1);
    repeat (18) step();
    press_ok(0, 1);
    chk_out("late press gen", 4'b0, 1'b0, 2'd1, 1'b0, 1'b0);
    show(2, 4'b0);
    to_press(2);
    press_ok(0, 2);
    chk_out("r2 second press", 4'b0, 1'b0, 2'd2, 1'b0, 1'b0);
    btn = rotl(oh(1));
    step();
    chk_out("wrong check", 4'b0, 1'b0, 2'd2, 1'b0, 1'b0);
    step();
    chk_out("wrong lose", oh(1), 1'b0, 2'd2, 1'b0, 1'b1);
    btn = 4'b0;
    step();
    chk_out("lose hold", oh(1), 1'b0, 2'd2, 1'b0, 1'b1);

    // Multi-bit press containing the correct bit still loses.
    new_game();
    show(1, 4'b0);
    to_press(1);
    w = oh(0) | rotl(oh(0));
    btn = w;
    step();
    chk_out("multi check", 4'b0, 1'b0, 2'd1, 1'b0, 1'b0);
    step();
    chk_out("multi lose", oh(0), 1'b0, 2'd1, 1'b0, 1'b1);
    btn = 4'b0;

    // Reset during SHOW_ON overrides start and btn.
    new_game();
    capture(0);
    step();
    chk_out("rst pre off0", 4'b0, 1'b1, 2'd1, 1'b0, 1'b0);
    step();
    chk_out("rst pre off1", 4'b0, 1'b1, 2'd1, 1'b0, 1'b0);
    step();
    chk_out("rst pre on", oh(0), 1'b1, 2'd1, 1'b0, 1'b0);
    rst   = 1'b1;
    start = 1'b1;
    btn   = 4'hF;
    step();
    chk_out("rst mid game", 4'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    rst   = 1'b0;
    start = 1'b0;
    btn   = 4'b0;
    step();
    chk_out("idle after rst", 4'b0, 1'b0, 2'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simon_game_param.md
Name: simon_game_param

Overview:
- Parametrised successor to the fixed 4-button, 4-step Simon controller.
- Supports N_BTN buttons/LEDs and sequences up to MAX_LEN symbols.
- Uses classic growing rounds: round k plays k symbols, then the player repeats them.
- Adds an LFSR symbol source, a player input timeout, and a round/score output. Sits between debounced, synchronised button inputs and the LED/status drivers.

Parameters:
- N_BTN, 4, number of buttons/LEDs (2..8)
- MAX_LEN, 16, longest sequence; reaching it is a win (1..64)
- ON_CYC, 200, clk cycles each LED is lit during playback
- OFF_CYC, 200, dark gap cycles between playback symbols and before the first symbol
- TIMEOUT_CYC, 16000, max idle cycles waiting for a press; exceeding it is a loss
- SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  level; sampled in IDLE, WIN or LOSE to begin a new game
- btn  in  N_BTN  button levels, already debounced and synchronised
- led  out  N_BTN  LED drive
- busy  out  1  high while showing the sequence (SHOW_OFF or SHOW_ON)
- round  out  $clog2(MAX_LEN+1)  current sequence length; 0 in IDLE
- win  out  1  high in WIN
- lose  out  1  high in LOSE

Behaviour:
- Reset state: IDLE, all outputs 0, LFSR=SEED, all counters 0.
- All outputs are registered and decoded from state and registers. No output has a combinational path from btn.
- LFSR: 16-bit Galois, taps 0xB400, advances every cycle including IDLE. Symbol = lfsr % N_BTN, width SYM_W=$clog2(N_BTN).
- Sequence memory: MAX_LEN x SYM_W register array. Not cleared on reset; entries at or beyond round are don't-care.
- IDLE: on start, go to GEN.
- GEN (1 cycle): mem[round] <= symbol; round <= round+1; idx <= 0; timer <= 0; go to SHOW_OFF.
- SHOW_OFF: led=0. When timer==OFF_CYC-1: clear timer; go to SHOW_ON if idx<round, else to WAIT_REL with idx <= 0.
- SHOW_ON: led = one-hot(mem[idx]). When timer==ON_CYC-1: idx++, clear timer, go to SHOW_OFF.
- Playback gaps: an OFF gap precedes the first symbol and follows the last one.
- WAIT_REL: led=0. When btn==0, clear timer and go to WAIT_PRESS. There is no timeout in this state.
- WAIT_PRESS: led=0; timer counts.
  - btn!=0: latch btn into pbtn, go to CHECK.
  - timer==TIMEOUT_CYC-1 with btn==0: go to LOSE.
- CHECK (1 cycle): correct iff pbtn == one-hot(mem[idx]). Any multi-bit or wrong press goes to LOSE. Correct press goes to ECHO.
- ECHO: led=pbtn. Wait for btn==0, then:
  - idx+1<round: idx++, clear timer, go to WAIT_PRESS.
  - idx+1==round and round==MAX_LEN: go to WIN.
  - otherwise: go to GEN.
- WIN: led all-ones, win=1. LOSE: led=one-hot(mem[idx]) (shows the expected symbol), lose=1.
- WIN/LOSE exit: on start, round <= 0 and go to GEN. This is a new game and the LFSR is not reseeded.
- start is ignored in all other states.
- Buttons pressed during playback are ignored. WAIT_REL prevents a held button from registering as the first press.
- rst mid-game: returns to IDLE on the next edge and overrides all other inputs.
- Counter widths: $clog2 of the largest of ON_CYC, OFF_CYC and TIMEOUT_CYC. No wrap occurs because every counter clears at its terminal count.

Decomposition:
- simon_pkg:
  - state enum: IDLE, GEN, SHOW_OFF, SHOW_ON, WAIT_REL, WAIT_PRESS, CHECK, ECHO, WIN, LOSE.
  - LFSR_TAPS constant.
  - onehot(sym, n) function.
- Sub-module simon_lfsr: 16-bit, parameter SEED, free-running, output q.

Test Plan (use N_BTN=4, MAX_LEN=3, ON_CYC=4, OFF_CYC=2, TIMEOUT_CYC=20):
- Reset then start -> round=1; led=0 for 2 cycles, then one-hot(mem[0]) for 4 cycles, then 2 dark cycles; busy high throughout.
- Correct play through all 3 rounds, each press held 3 cycles -> round takes 1,2,3; win=1 and led=4'b1111 after the third release.
- Round 2, first symbol correct, second press wrong -> lose=1 one cycle after CHECK; led = expected symbol; round stays 2.
- Press btn=4'b0011 when the expected symbol is 0 -> LOSE.
- WAIT_PRESS with no input for 20 cycles -> lose=1 at cycle 21. A press arriving at cycle 19 is accepted.
- Button held through playback -> no CHECK until release and a fresh press. rst asserted in SHOW_ON -> IDLE on the next cycle with all outputs 0; start in LOSE -> round=1, new game.
